data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Block-addressed backing data memory. It is the responder side of the cache-to-memory handshake (read/write/address/writedata/readdata/busywait).
- Holds 64 blocks of 32 bits and serves one whole-block read or write at a time.
- Each access takes a fixed multi-cycle latency; busywait stalls the requesting cache controller until the access completes.
- Sits between the data cache FSM and the top-level CPU system.

Parameters:
- ADDR_W, 6, block address width
- DEPTH, 64, number of blocks (2**ADDR_W)
- WORD_W, 32, block width in bits
- LATENCY, 5, clock edges from request capture to access completion; legal range 1 to 255

Ports:
- clock  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- read  input  1  block read request, level, held until busywait low
- write  input  1  block write request, level, held until busywait low
- address  input  ADDR_W  block address {tag,index}
- writedata  input  WORD_W  block to store on write
- readdata  output  WORD_W  block returned on read
- busywait  output  1  high while a request is pending or in progress

Behaviour:
- Reset (asynchronous, active-high):
  - state to IDLE, counter to 0, readdata to 0, all DEPTH words cleared to 0.
  - busywait follows its combinational rule, so it is 0 unless a request is present.
- States: IDLE, BUSY, DONE.
- IDLE:
  - busywait = read | write, combinational, so the requester sees the stall in the same cycle.
  - On a rising edge with read|write=1: capture address, writedata and op (write has priority if both are high), load counter = LATENCY-1, go to BUSY.
- BUSY:
  - busywait=1.
  - Each edge with counter>0: decrement.
  - On the edge with counter==0: perform the access and go to DONE.
    - Read: readdata <= mem[captured address].
    - Write: mem[captured address] <= captured writedata.
- DONE:
  - busywait=0; read and write are ignored for exactly one cycle.
  - Next edge: go to IDLE with no sampling. This lets the requester drop or change its request (e.g. writeback followed by refill) without a spurious re-issue.
- Latency:
  - Request captured at edge E0; access performed at edge E0+LATENCY.
  - busywait is low for the single DONE cycle.
  - A new request can be captured at E0+LATENCY+2 at the earliest.
- Captured operands:
  - Operands are latched at capture; changes to address, writedata or the request level during BUSY have no effect.
  - A request dropped mid-BUSY still completes.
- readdata holds its last value until the next read completes; writes do not alter it.
- A write followed by a read of the same address returns the new data (the write completes before the read is captured).
- Reset during BUSY aborts the access: memory is cleared and state returns to IDLE.
- Reset removal is treated like a normal IDLE entry.
- The address always fits, since DEPTH = 2**ADDR_W; no out-of-range case exists.

Decomposition:
- Shared package mem_pkg holds:
  - state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10)
  - the ADDR_W/WORD_W defaults
  - the LATENCY default shared with the cache testbench timing
- Optional sub-module mem_latency_counter: load, decrement and zero flag, width $clog2(LATENCY+1). Everything else is flat in data_memory.

Test Plan:
- Reset then read addr 6'h05 with LATENCY=5 -> busywait high in the request cycle and for 5 edges; readdata=32'h0 at completion; busywait low for one cycle.
- Write 32'hDEADBEEF to 6'h2A, then read 6'h2A -> second access returns 32'hDEADBEEF exactly 5 edges after its capture.
- Writeback then refill, cache-style: write 32'h11223344 to 6'h10, requester switches to a read of 6'h30 on the DONE edge -> the read is captured one edge later (no double write); readdata=32'h0; mem[6'h10]=32'h11223344.
- Change address and writedata to 6'h3F/32'hFFFFFFFF mid-BUSY of a write to 6'h01 with 32'hA5A5A5A5 -> mem[6'h01]=32'hA5A5A5A5 and mem[6'h3F] unchanged.
- Assert reset 2 edges into a write of 32'hCAFEF00D to 6'h07 -> busywait drops immediately (no request held); mem[6'h07]=0; a later read returns 32'h0.
- read and write both high with writedata 32'h0000BEEF at 6'h02 -> treated as a write; a subsequent read of 6'h02 returns 32'h0000BEEF; readdata unchanged during the write.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the block-addressed backing data memory:
// FSM state encoding, default geometry and default access latency.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W  = 6;
    localparam int unsigned MEM_WORD_W  = 32;
    localparam int unsigned MEM_LATENCY = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mem_state_e;

    // Counter must hold LATENCY-1; a width of at least 1 covers LATENCY=1.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat < 2) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// Cache-to-memory handshake: the cache is master, the data memory is slave.
interface data_memory_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned WORD_W = 32
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [WORD_W-1:0] writedata;
    logic [WORD_W-1:0] readdata;
    logic              busywait;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait
    );
endinterface

// File: rtl/mem_latency_counter.sv
// Down-counter timing one memory access: loads LATENCY-1 on capture and
// flags zero on the cycle the access is due.
import mem_pkg::*;

module mem_latency_counter #(
    parameter int unsigned LATENCY = MEM_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);
    localparam int unsigned CNT_W = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/data_memory.sv
// Backing data memory: 64 x 32-bit blocks, one whole-block access at a time
// with a fixed latency; busywait stalls the cache controller meanwhile.
import mem_pkg::*;

module data_memory #(
    parameter int unsigned ADDR_W  = MEM_ADDR_W,
    parameter int unsigned DEPTH   = 2 ** ADDR_W,
    parameter int unsigned WORD_W  = MEM_WORD_W,
    parameter int unsigned LATENCY = MEM_LATENCY
) (
    input  logic         clock,
    input  logic         reset,
    data_memory_if.slave bus
);
    mem_state_e        r_state;
    mem_state_e        w_next_state;
    logic              w_capture;
    logic              w_dec;
    logic              w_access;
    logic              w_busywait;
    logic              w_cnt_zero;

    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic              r_op_write;
    logic [WORD_W-1:0] r_readdata;
    logic [WORD_W-1:0] r_mem [DEPTH];

    mem_latency_counter #(
        .LATENCY (LATENCY)
    ) u_cnt (
        .clk    (clock),
        .rst    (reset),
        .i_load (w_capture),
        .i_dec  (w_dec),
        .o_zero (w_cnt_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // DONE never samples the request so a requester switching ops on the
    // completion edge cannot trigger a re-issue of the old op.
    always_comb begin
        w_next_state = r_state;
        w_busywait   = 1'b0;
        w_capture    = 1'b0;
        w_dec        = 1'b0;
        w_access     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_busywait = bus.read | bus.write;
                if (bus.read | bus.write) begin
                    w_capture    = 1'b1;
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                w_busywait = 1'b1;
                if (w_cnt_zero) begin
                    w_access     = 1'b1;
                    w_next_state = DONE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_op_write <= 1'b0;
            r_readdata <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_capture) begin
                r_addr     <= bus.address;
                r_wdata    <= bus.writedata;
                r_op_write <= bus.write;
            end
            if (w_access) begin
                if (r_op_write) begin
                    r_mem[r_addr] <= r_wdata;
                end else begin
                    r_readdata <= r_mem[r_addr];
                end
            end
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.busywait = w_busywait;
endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory with hand-computed expectations.
module tb_data_memory;
    localparam int unsigned LAT = 5;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   n;

    data_memory_if #(.ADDR_W(6), .WORD_W(32)) bus ();

    data_memory #(
        .ADDR_W  (6),
        .DEPTH   (64),
        .WORD_W  (32),
        .LATENCY (LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a request and count edges until busywait is seen low (bounded).
    task automatic run_req(input logic w, input logic r, input logic [5:0] a,
                           input logic [31:0] d, output int cnt);
        bus.write     = w;
        bus.read      = r;
        bus.address   = a;
        bus.writedata = d;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (bus.busywait && cnt < 20);
    endtask

    task automatic release_req();
        bus.read  = 1'b0;
        bus.write = 1'b0;
        tick();
    endtask

    task automatic do_read(input string tag, input logic [5:0] a, input logic [31:0] exp);
        int c;
        run_req(1'b0, 1'b1, a, 32'h0, c);
        check({tag, "_lat"}, 32'(c), 32'(LAT + 1));
        check(tag, bus.readdata, exp);
        release_req();
    endtask

    task automatic do_write(input string tag, input logic [5:0] a, input logic [31:0] d);
        int c;
        run_req(1'b1, 1'b0, a, d, c);
        check({tag, "_lat"}, 32'(c), 32'(LAT + 1));
        release_req();
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.address   = '0;
        bus.writedata = '0;
        tick();
        tick();
        check("rst_busy", {31'b0, bus.busywait}, 32'h0);
        check("rst_rdata", bus.readdata, 32'h0);
        reset = 1'b0;
        tick();

        // Read 0x05: stall visible in request cycle and for 5 edges.
        bus.read    = 1'b1;
        bus.address = 6'h05;
        #1;
        check("rd05_req_cycle", {31'b0, bus.busywait}, 32'h1);
        for (int i = 0; i < int'(LAT); i++) begin
            tick();
            check($sformatf("rd05_busy_e%0d", i), {31'b0, bus.busywait}, 32'h1);
        end
        tick();
        check("rd05_done_busy", {31'b0, bus.busywait}, 32'h0);
        check("rd05_data", bus.readdata, 32'h0);
        release_req();
        check("rd05_idle_busy", {31'b0, bus.busywait}, 32'h0);

        // Write then read back.
        do_write("wr2a", 6'h2A, 32'hDEADBEEF);
        do_read("rd2a", 6'h2A, 32'hDEADBEEF);

        // Writeback then refill: switch to read on the DONE cycle.
        run_req(1'b1, 1'b0, 6'h10, 32'h11223344, n);
        check("wb_lat", 32'(n), 32'(LAT + 1));
        bus.write   = 1'b0;
        bus.read    = 1'b1;
        bus.address = 6'h30;
        #1;
        check("wb_done_ignored", {31'b0, bus.busywait}, 32'h0);
        n = 0;
        do begin
            tick();
            n++;
        end while ((bus.busywait || n == 1) && n < 20);
        check("refill_lat", 32'(n), 32'(LAT + 2));
        check("refill_data", bus.readdata, 32'h0);
        release_req();
        do_read("rd10", 6'h10, 32'h11223344);

        // Operands change mid-BUSY; the captured ones must be used.
        bus.write     = 1'b1;
        bus.address   = 6'h01;
        bus.writedata = 32'hA5A5A5A5;
        tick();
        tick();
        bus.address   = 6'h3F;
        bus.writedata = 32'hFFFFFFFF;
        n = 2;
        while (bus.busywait && n < 20) begin
            tick();
            n++;
        end
        check("midbusy_lat", 32'(n), 32'(LAT + 1));
        release_req();
        do_read("rd3f", 6'h3F, 32'h0);
        do_read("rd01", 6'h01, 32'hA5A5A5A5);

        // Both high: write wins, readdata untouched by the write.
        run_req(1'b1, 1'b1, 6'h02, 32'h0000BEEF, n);
        check("both_lat", 32'(n), 32'(LAT + 1));
        check("both_rdata_kept", bus.readdata, 32'hA5A5A5A5);
        release_req();
        do_read("rd02", 6'h02, 32'h0000BEEF);

        // Reset two edges into a write aborts it and clears memory.
        bus.write     = 1'b1;
        bus.address   = 6'h07;
        bus.writedata = 32'hCAFEF00D;
        tick();
        tick();
        tick();
        check("abort_busy_pre", {31'b0, bus.busywait}, 32'h1);
        reset     = 1'b1;
        bus.write = 1'b0;
        #1;
        check("abort_busy", {31'b0, bus.busywait}, 32'h0);
        check("abort_rdata", bus.readdata, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        do_read("rd07_after_rst", 6'h07, 32'h0);
        do_read("rd2a_after_rst", 6'h2A, 32'h0);
        do_read("rd02_after_rst", 6'h02, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
